// File: rtl/bus_xfer_ctrl_if.sv
// Command and strobe bundle between the bus-transfer controller and its environment.
// Handshake: a command transfers at any posedge where cmd_valid && cmd_ready; cmd_* may change afterwards.
interface bus_xfer_ctrl_if #(
  parameter int NREG = 4,
  parameter int DW   = 8,
  parameter int IW   = 2
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [IW-1:0]   cmd_src;
  logic [IW-1:0]   cmd_dst;
  logic [DW-1:0]   cmd_imm;
  logic [DW-1:0]   bus_in;
  logic [NREG-1:0] oa;
  logic [NREG-1:0] wa;
  logic            imm_oe;
  logic [DW-1:0]   bus_out;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            err;
  logic            busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, bus_in,
    output cmd_ready, oa, wa, imm_oe, bus_out, rd_data, rd_valid, err, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, bus_in,
    input  cmd_ready, oa, wa, imm_oe, bus_out, rd_data, rd_valid, err, busy
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer initiator: sequences one driver (register oa or immediate) per
// transfer through a settle cycle and a latch cycle, so the bus never has two drivers.
module bus_xfer_ctrl #(
  parameter int NREG = 4,
  parameter int DW   = 8,
  parameter int IW   = 2
) (
  input  logic               clk,
  input  logic               clr,
  bus_xfer_ctrl_if.master    bus,
  output logic [1:0]         state_o
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  localparam logic [1:0]      OP_MOVE  = 2'b00;
  localparam logic [1:0]      OP_LOADI = 2'b01;
  localparam logic [1:0]      OP_READ  = 2'b10;
  localparam logic [IW:0]     NREG_L   = (IW+1)'(NREG);
  localparam logic [NREG-1:0] ONE      = {{(NREG-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [IW-1:0]   dst_q, dst_d;
  logic [NREG-1:0] oa_q, oa_d;
  logic [NREG-1:0] wa_q, wa_d;
  logic            imm_oe_q, imm_oe_d;
  logic [DW-1:0]   bus_out_q, bus_out_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            err_q, err_d;
  logic            cmd_ready;
  logic            src_ok, dst_ok, legal;

  assign cmd_ready = (state_q == S_IDLE) && !clr;
  assign src_ok    = {1'b0, bus.cmd_src} < NREG_L;
  assign dst_ok    = {1'b0, bus.cmd_dst} < NREG_L;

  // Only the indices an opcode actually uses are range-checked.
  always_comb begin
    legal = 1'b0;
    case (bus.cmd_op)
      OP_MOVE:  legal = src_ok && dst_ok && (bus.cmd_src != bus.cmd_dst);
      OP_LOADI: legal = dst_ok;
      OP_READ:  legal = src_ok;
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    oa_d       = oa_q;
    wa_d       = wa_q;
    imm_oe_d   = imm_oe_q;
    bus_out_d  = bus_out_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          op_d  = bus.cmd_op;
          dst_d = bus.cmd_dst;
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            state_d = S_DRIVE;
            if (bus.cmd_op == OP_LOADI) begin
              imm_oe_d  = 1'b1;
              bus_out_d = bus.cmd_imm;
            end else begin
              oa_d = ONE << bus.cmd_src;
            end
          end
        end
      end
      S_DRIVE: begin
        state_d = S_LATCH;
        if (op_q != OP_READ) wa_d = ONE << dst_q;
      end
      S_LATCH: begin
        state_d  = S_IDLE;
        oa_d     = '0;
        wa_d     = '0;
        imm_oe_d = 1'b0;
        if (op_q == OP_READ) begin
          rd_data_d  = bus.bus_in;
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        oa_d     = '0;
        wa_d     = '0;
        imm_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      dst_q      <= '0;
      oa_q       <= '0;
      wa_q       <= '0;
      imm_oe_q   <= 1'b0;
      bus_out_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      oa_q       <= oa_d;
      wa_q       <= wa_d;
      imm_oe_q   <= imm_oe_d;
      bus_out_q  <= bus_out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.oa        = oa_q;
  assign bus.wa        = wa_q;
  assign bus.imm_oe    = imm_oe_q;
  assign bus.bus_out   = bus_out_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign state_o       = state_q;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: four modelled bus registers respond to oa/wa, and a
// command-level register model predicts their contents and every READ result.
module tb_bus_xfer_ctrl;
  localparam int NREG = 4;
  localparam int DW   = 8;
  localparam int IW   = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  bit         mon_en = 1'b0;

  logic [DW-1:0] resp  [NREG] = '{8'h10, 8'h11, 8'h12, 8'h13};
  logic [DW-1:0] ref_m [NREG] = '{8'h10, 8'h11, 8'h12, 8'h13};
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] bus_val;

  bus_xfer_ctrl_if #(.NREG(NREG), .DW(DW), .IW(IW)) ifc ();

  bus_xfer_ctrl #(.NREG(NREG), .DW(DW), .IW(IW)) dut (
    .clk     (clk),
    .clr     (clr),
    .bus     (ifc),
    .state_o (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    bus_val = '0;
    if (ifc.imm_oe === 1'b1) bus_val = ifc.bus_out;
    for (int k = 0; k < NREG; k++)
      if (ifc.oa[k] === 1'b1) bus_val = resp[k];
  end
  assign ifc.bus_in = bus_val;

  always @(posedge clk)
    for (int k = 0; k < NREG; k++)
      if (ifc.wa[k] === 1'b1) resp[k] <= bus_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !clr) begin
      check_eq("inv_one_driver", 32'(($countones(ifc.oa) + ifc.imm_oe) <= 1), 1);
      check_eq("inv_one_wa", 32'($countones(ifc.wa) <= 1), 1);
      check_eq("inv_wa_driven", 32'((ifc.wa == 0) || (ifc.oa != 0) || ifc.imm_oe), 1);
      check_eq("inv_oa_wa_overlap", 32'(ifc.oa & ifc.wa), 0);
      if (ifc.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) check_eq("rd_unexpected", 32'(ifc.rd_valid), 0);
        else check_eq("rd_data", 32'(ifc.rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                           input logic [7:0] imm);
    case (op)
      2'b00: ref_m[dst] = ref_m[src];
      2'b01: ref_m[dst] = imm;
      2'b10: exp_q.push_back(ref_m[src]);
      default: ;
    endcase
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n < 10), 1);
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                           input logic [7:0] imm);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_src   = src;
    ifc.cmd_dst   = dst;
    ifc.cmd_imm   = imm;
  endtask

  task automatic scramble_cmd();
    ifc.cmd_op  = 2'($urandom_range(0, 3));
    ifc.cmd_src = 3'($urandom_range(0, 7));
    ifc.cmd_dst = 3'($urandom_range(0, 7));
    ifc.cmd_imm = 8'($urandom_range(0, 255));
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                      input logic [7:0] imm);
    bit         legal;
    logic [3:0] exp_oa, exp_wa;
    case (op)
      2'b00:   legal = (src < 4) && (dst < 4) && (src != dst);
      2'b01:   legal = (dst < 4);
      2'b10:   legal = (src < 4);
      default: legal = 1'b0;
    endcase
    exp_oa = (op == 2'b01) ? 4'b0000 : 4'b0001 << src;
    exp_wa = (op == 2'b10) ? 4'b0000 : 4'b0001 << dst;
    wait_ready("ready_timeout");
    drive_cmd(op, src, dst, imm);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    scramble_cmd();
    if (!legal) begin
      check_eq("ill_err", 32'(ifc.err), 1);
      check_eq("ill_busy", 32'(ifc.busy), 0);
      check_eq("ill_strobes", 32'({ifc.oa, ifc.wa, ifc.imm_oe}), 0);
      @(negedge clk);
      check_eq("ill_err_pulse", 32'(ifc.err), 0);
      check_eq("ill_ready", 32'(ifc.cmd_ready), 1);
    end else begin
      model_cmd(op, src, dst, imm);
      check_eq("drv_busy", 32'(ifc.busy), 1);
      check_eq("drv_oa", 32'(ifc.oa), 32'(exp_oa));
      check_eq("drv_imm_oe", 32'(ifc.imm_oe), 32'(op == 2'b01));
      check_eq("drv_wa", 32'(ifc.wa), 0);
      check_eq("drv_err_rdv", 32'({ifc.err, ifc.rd_valid}), 0);
      if (op == 2'b01) check_eq("drv_bus_out", 32'(ifc.bus_out), 32'(imm));
      @(negedge clk);
      check_eq("lat_oa", 32'(ifc.oa), 32'(exp_oa));
      check_eq("lat_imm_oe", 32'(ifc.imm_oe), 32'(op == 2'b01));
      check_eq("lat_wa", 32'(ifc.wa), 32'(exp_wa));
      @(negedge clk);
      check_eq("end_busy", 32'(ifc.busy), 0);
      check_eq("end_strobes", 32'({ifc.oa, ifc.wa, ifc.imm_oe}), 0);
      check_eq("end_rd_valid", 32'(ifc.rd_valid), 32'(op == 2'b10));
      check_eq("end_ready", 32'(ifc.cmd_ready), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    logic [2:0] src, dst;
    logic [7:0] imm;
    int         acc [10];
    int         n;

    // Reset with a command pending.
    clr = 1'b1;
    drive_cmd(2'b01, 3'd1, 3'd1, 8'hAA);
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(ifc.cmd_ready), 0);
    check_eq("rst_outputs", 32'({ifc.oa, ifc.wa, ifc.imm_oe, ifc.rd_valid, ifc.err, ifc.busy}), 0);
    check_eq("rst_bus_out", 32'(ifc.bus_out), 0);
    check_eq("rst_rd_data", 32'(ifc.rd_data), 0);
    clr = 1'b0;
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_after", 32'(ifc.cmd_ready), 1);
    mon_en = 1'b1;

    // Directed transfers.
    send(2'b01, 3'd0, 3'd2, 8'h55);
    check_eq("reg2_after_loadi", 32'(resp[2]), 32'(8'h55));
    send(2'b00, 3'd2, 3'd0, 8'h00);
    check_eq("reg0_after_move", 32'(resp[0]), 32'(8'h55));
    send(2'b10, 3'd0, 3'd0, 8'h00);
    check_eq("rd_data_hold", 32'(ifc.rd_data), 32'(8'h55));

    // Illegal commands.
    send(2'b00, 3'd1, 3'd1, 8'h00);
    send(2'b11, 3'd0, 3'd1, 8'h00);
    send(2'b01, 3'd0, 3'd5, 8'h77);
    send(2'b10, 3'd6, 3'd0, 8'h00);

    // Reset during LATCH: the edge that samples clr also ends LATCH, so dst is written.
    send(2'b01, 3'd0, 3'd1, 8'hC3);
    wait_ready("clr_lat_ready");
    drive_cmd(2'b00, 3'd1, 3'd3, 8'h00);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    ref_m[3] = ref_m[1];
    @(negedge clk);
    check_eq("clr_lat_strobes", 32'({ifc.oa, ifc.wa, ifc.imm_oe}), 0);
    check_eq("clr_lat_busy", 32'(ifc.busy), 0);
    clr = 1'b0;
    @(negedge clk);
    check_eq("clr_lat_reg3", 32'(resp[3]), 32'(ref_m[3]));

    // Reset during DRIVE: the transfer is discarded before any write strobe.
    wait_ready("clr_drv_ready");
    drive_cmd(2'b00, 3'd1, 3'd2, 8'h00);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    check_eq("clr_drv_strobes", 32'({ifc.oa, ifc.wa, ifc.imm_oe}), 0);
    check_eq("clr_drv_busy", 32'(ifc.busy), 0);
    clr = 1'b0;
    @(negedge clk);
    check_eq("clr_drv_reg2", 32'(resp[2]), 32'(ref_m[2]));

    // Random legal stream with cmd_valid held high.
    for (int i = 0; i < 10; i++) begin
      op  = 2'($urandom_range(0, 2));
      src = 3'($urandom_range(0, 3));
      dst = 3'((32'(src) + $urandom_range(1, 3)) % 4);
      imm = 8'($urandom_range(0, 255));
      drive_cmd(op, src, dst, imm);
      n = 0;
      while (ifc.cmd_ready !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check_eq("s_ready_timeout", 32'(n < 10), 1);
      model_cmd(op, src, dst, imm);
      acc[i] = cyc;
      @(negedge clk);
      check_eq("s_busy", 32'(ifc.busy), 1);
      if (i > 0) check_eq("s_accept_gap", 32'(acc[i] - acc[i-1]), 3);
    end
    ifc.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < NREG; k++)
      check_eq($sformatf("reg%0d_final", k), 32'(resp[k]), 32'(ref_m[k]));
    check_eq("rd_pending", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
